fetch_stage_ctrl: RTL and testbench
===================================

Name: fetch_stage_ctrl

Overview:
- Fetch-stage PC sequencer plus IF/ID pipeline register.
- Consumes the execute-stage branch decision (PCSrcE, from branch-taken logic OR jump) and PCTargetE.
- Issues instruction-memory requests over a req/ready handshake and delivers fetched instructions to decode.
- Tolerates multi-cycle memory latency; redirects that arrive during an outstanding fetch are queued until that fetch completes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- XLEN, 32, address/instruction width. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- StallF  in  1  hazard unit: hold PC.
- StallD  in  1  hazard unit: hold IF/ID.
- PCSrcE  in  1  execute stage: branch taken or jump; redirect request.
- PCTargetE  in  XLEN  execute stage redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; always equals PCF.
- imem_ready  in  1  imem_rdata valid this cycle; completes the request.
- imem_rdata  in  XLEN  fetched instruction.
- PCF  out  XLEN  current fetch PC.
- InstrD  out  XLEN  decode-stage instruction.
- PCD  out  XLEN  decode-stage PC.
- PCPlus4D  out  XLEN  PCD+4.
- ValidD  out  1  InstrD is a real instruction.
- FlushE  out  1  combinational copy of PCSrcE; bubbles ID/EX.

Behaviour:
- Reset values (async, on any cycle, including mid-fetch): PCF=RESET_PC, state=FETCH, InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0, ValidD=0, redirect buffer cleared.
- imem_req=1 whenever rst_n=1. imem_addr=PCF, held stable while imem_req=1 and imem_ready=0.
- Fetch completes in the cycle imem_ready=1. Latency is 0 wait states when ready is tied high, giving one instruction per cycle.
- State FETCH:
  - PCSrcE=1 and imem_ready=1: PCF<=PCTargetE; fetched data discarded.
  - PCSrcE=1 and imem_ready=0: redir_q<=PCTargetE; go to DROP; PCF held.
  - PCSrcE=0, imem_ready=1, StallF=0: PCF<=PCF+4, wrapping modulo 2^32.
  - Otherwise: PCF held. If StallF=1 with ready=1, the same address is re-fetched next cycle.
- State DROP (wrong-path fetch outstanding):
  - PCSrcE=1: redir_q<=PCTargetE; the newest redirect wins.
  - On imem_ready=1: data discarded; PCF<=(PCSrcE ? PCTargetE : redir_q); go to FETCH.
  - StallF is ignored in DROP.
- IF/ID update, highest priority first:
  1. PCSrcE=1: flush. InstrD<=NOP, ValidD<=0. Overrides StallD.
  2. StallD=1: hold all IF/ID registers.
  3. State FETCH, imem_ready=1, StallF=0: InstrD<=imem_rdata, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1.
  4. Otherwise: bubble. InstrD<=NOP, ValidD<=0; PCD and PCPlus4D hold.
- FlushE=PCSrcE, combinational, no reset dependence beyond its input.
- PCTargetE is used as given; no alignment check.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt[31:0] and flush_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each IF/ID load (rule 3).
  - flush_cnt increments each cycle PCSrcE=1.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC.
  - State enum {FETCH, DROP}.
- One sub-module: if_id_reg, holding InstrD/PCD/PCPlus4D/ValidD with flush, stall and load controls.
- PC/FSM logic stays in the top.

Test Plan:
- Reset, then imem_ready=1 held: imem_addr sequence 0x0,0x4,0x8. InstrD follows imem_rdata one cycle later with ValidD=1; PCPlus4D=PCD+4.
- At PCF=0x10, PCSrcE=1, PCTargetE=0x100, ready=1: next PCF=0x100, ValidD=0, InstrD=NOP, FlushE=1 in the same cycle.
- ready=0 for 3 cycles at PCF=0x20, PCSrcE pulse with target 0x200 in cycle 1: imem_addr stays 0x20 until ready. The returned word is dropped (ValidD=0), then PCF=0x200.
- In DROP, a second redirect to 0x300 arrives before ready: PCF becomes 0x300, not 0x200.
- StallF=StallD=1 for 2 cycles, then released: PCF and IF/ID hold. Sequence resumes with no lost or duplicated instruction. If PCSrcE=1 arrives during the stall, the flush wins.
- rst_n asserted low mid-DROP: immediately PCF=RESET_PC and ValidD=0; after release, fetch restarts at RESET_PC with the redirect buffer cleared.

Source files
------------

// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, reset PC and FSM states.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_stage_ctrl_if_id_reg.sv
// IF/ID pipeline register. Priority: flush, then stall, then load, else bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            valid_q, valid_d;

  // Next-state selection for the decode-stage registers
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      instr_d = instr_q;
      valid_d = valid_q;
    end else if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      pc4_d   = pc_plus4(pc_i);
      valid_d = 1'b1;
    end else begin
      // Bubble keeps the old PC pair so decode still sees a coherent PCD/PCPlus4D
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  // Decode-stage register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch-stage PC sequencer with redirect buffering across outstanding fetches.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic            FlushE
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic            load_s;

  assign imem_req  = rst_n;
  assign imem_addr = pcf_q;
  assign PCF       = pcf_q;
  assign FlushE    = PCSrcE;

  // Only a completed, non-stalled, on-path fetch may enter decode
  assign load_s = (state_q == FETCH) && imem_ready && !StallF;

  // PC / redirect-buffer next state
  always_comb begin
    state_d = state_q;
    pcf_d   = pcf_q;
    redir_d = redir_q;
    case (state_q)
      FETCH: begin
        if (PCSrcE) begin
          if (imem_ready) begin
            pcf_d = PCTargetE;
          end else begin
            redir_d = PCTargetE;
            state_d = DROP;
          end
        end else if (imem_ready && !StallF) begin
          pcf_d = pc_plus4(pcf_q);
        end else begin
          pcf_d = pcf_q;
        end
      end
      DROP: begin
        // Wrong-path fetch still outstanding; newest redirect wins
        if (PCSrcE) begin
          redir_d = PCTargetE;
        end else begin
          redir_d = redir_q;
        end
        if (imem_ready) begin
          pcf_d   = PCSrcE ? PCTargetE : redir_q;
          state_d = FETCH;
        end else begin
          pcf_d   = pcf_q;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // PC sequencer state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pcf_q   <= RESET_PC;
      redir_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pcf_q   <= pcf_d;
      redir_q <= redir_d;
    end
  end

  if_id_reg #(
    .XLEN(XLEN)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (PCSrcE),
    .stall_i   (StallD),
    .load_i    (load_s),
    .instr_i   (imem_rdata),
    .pc_i      (pcf_q),
    .instr_o   (InstrD),
    .pc_o      (PCD),
    .pc_plus4_o(PCPlus4D),
    .valid_o   (ValidD)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counter increments; a load only counts when flush and stall both let it through
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_s && !PCSrcE && !StallD) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else begin
      fetch_cnt_d = fetch_cnt_q;
    end
    if (PCSrcE) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Self-checking bench for fetch_stage_ctrl: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        StallF, StallD, PCSrcE, imem_ready;
  logic [31:0] PCTargetE, imem_rdata;
  logic        imem_req, ValidD, FlushE;
  logic [31:0] imem_addr, PCF, InstrD, PCD, PCPlus4D;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc, m_redir, m_instr, m_pcd, m_pc4d;
  logic        m_drop, m_valid;
  logic [31:0] m_fetches, m_flushes;

  fetch_stage_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .StallD    (StallD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .PCF       (PCF),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .FlushE    (FlushE)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt (fetch_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_redir = 32'h0; m_drop = 1'b0;
    m_instr = NOP; m_pcd = 32'h0; m_pc4d = 32'h0; m_valid = 1'b0;
    m_fetches = 32'h0; m_flushes = 32'h0;
  endtask

  // One clock of the architectural rules, using the inputs present before the edge
  task automatic model_clock(input logic sf, input logic sd, input logic ps,
                             input logic [31:0] tgt, input logic rdy, input logic [31:0] rdata);
    logic on_path_done;
    on_path_done = !m_drop && rdy && !sf;
    if (ps) begin
      m_instr = NOP; m_valid = 1'b0;
    end else if (!sd) begin
      if (on_path_done) begin
        m_instr = rdata; m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1'b1;
        m_fetches = m_fetches + 32'd1;
      end else begin
        m_instr = NOP; m_valid = 1'b0;
      end
    end
    if (ps) m_flushes = m_flushes + 32'd1;
    if (m_drop) begin
      if (ps) m_redir = tgt;
      if (rdy) begin
        m_pc = m_redir; m_drop = 1'b0;
      end
    end else if (ps) begin
      if (rdy) m_pc = tgt;
      else begin
        m_redir = tgt; m_drop = 1'b1;
      end
    end else if (rdy && !sf) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_regs();
    chk("PCF", PCF, m_pc);
    chk("InstrD", InstrD, m_instr);
    chk("PCD", PCD, m_pcd);
    chk("PCPlus4D", PCPlus4D, m_pc4d);
    chk("ValidD", {31'd0, ValidD}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, m_fetches);
    chk("flush_cnt", flush_cnt, m_flushes);
`endif
  endtask

  // Drive one cycle, check the combinational view, clock, then check registers
  task automatic step(input logic sf, input logic sd, input logic ps,
                      input logic [31:0] tgt, input logic rdy);
    logic [31:0] rd;
    rd = $urandom;
    StallF = sf; StallD = sd; PCSrcE = ps; PCTargetE = tgt;
    imem_ready = rdy; imem_rdata = rd;
    #1;
    chk("FlushE", {31'd0, FlushE}, {31'd0, ps});
    chk("imem_addr", imem_addr, m_pc);
    chk("imem_req", {31'd0, imem_req}, 32'd1);
    model_clock(sf, sd, ps, tgt, rdy, rd);
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    rst_n = 1'b0;
    StallF = 1'b0; StallD = 1'b0; PCSrcE = 1'b0; imem_ready = 1'b0;
    PCTargetE = 32'h0; imem_rdata = 32'h0;
    model_reset();
    #12;
    chk("rst_PCF", PCF, 32'h0);
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_ValidD", {31'd0, ValidD}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b1;

    // Streaming at full rate: 0x0, 0x4, 0x8, 0xC, then at 0x10
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("seq_pc_0x10", PCF, 32'h10);
    chk("seq_pcd_0xc", PCD, 32'hC);
    chk("seq_pc4d", PCPlus4D, 32'h10);

    // Redirect with a same-cycle completion
    step(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    chk("redir_pc", PCF, 32'h100);
    chk("redir_valid", {31'd0, ValidD}, 32'd0);
    chk("redir_nop", InstrD, NOP);

    // Redirect during a multi-cycle fetch at 0x20
    step(1'b0, 1'b0, 1'b1, 32'h20, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("drop_addr_held", imem_addr, 32'h20);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("drop_valid", {31'd0, ValidD}, 32'd0);
    chk("drop_pc", PCF, 32'h200);

    // Newest redirect wins while dropping
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("drop2_pc", PCF, 32'h300);

    // Stall both stages, release, then flush during a stall
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_pc", PCF, 32'h304);
    chk("stall_pcd", PCD, 32'h300);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("stall_resume_pcd", PCD, 32'h304);
    step(1'b1, 1'b1, 1'b1, 32'h400, 1'b1);
    chk("stall_flush_valid", {31'd0, ValidD}, 32'd0);
    chk("stall_flush_pc", PCF, 32'h400);

    // PC wrap at the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("wrap_pc", PCF, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 6) == 0), $urandom, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset while dropping
    step(1'b0, 1'b0, 1'b1, 32'h500, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h700, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_PCF", PCF, 32'h0);
    chk("arst_ValidD", {31'd0, ValidD}, 32'd0);
    chk("arst_InstrD", InstrD, NOP);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("arst_restart_pc", PCF, 32'h8);
    chk("arst_restart_pcd", PCD, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
